// File: rtl/periph_req_arbiter.sv
// Round-robin arbiter from 31 peripheral TX/RX DMA requests (62 slots) to a single DMA channel engine.
// Optional BUSY watchdog enabled by defining PERIPH_ARB_TIMEOUT_EN (adds TIMEOUT_CYCLES and xfer_timeout).
module periph_req_arbiter
`ifdef PERIPH_ARB_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
)
`endif
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:1] periph_tx_req,
  input  logic [31:1] periph_rx_req,
  input  logic [31:1] periph_tx_en,
  input  logic [31:1] periph_rx_en,
  output logic [31:1] periph_tx_clr,
  output logic [31:1] periph_rx_clr,
  output logic        grant_valid,
  output logic [4:0]  grant_periph,
  output logic        grant_dir,
  input  logic        grant_ready,
  input  logic        xfer_done,
  output logic        arb_busy
`ifdef PERIPH_ARB_TIMEOUT_EN
  ,
  output logic        xfer_timeout
`endif
);

  localparam int         NSLOTS    = 62;
  localparam logic [5:0] LAST_SLOT = 6'd61;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    BUSY,
    CLEAR,
    SETTLE
  } state_t;

  state_t      state, state_next;
  logic [61:0] eligible;
  logic [5:0]  rr_ptr, rr_ptr_next;
  logic        win_found;
  logic [5:0]  win_slot;
  logic [6:0]  cand;
  logic        grant_valid_next;
  logic [4:0]  grant_periph_next;
  logic        grant_dir_next;
  logic [31:1] served_tx, served_rx;
  logic [31:1] tx_clr_next, rx_clr_next;
  logic        arb_busy_next;

`ifdef PERIPH_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_cnt, wd_cnt_next;
  logic        wd_expire;
  logic        xfer_timeout_next;

  assign wd_expire = (wd_cnt == TIMEOUT_LAST);
`endif

  // Slot 2(p-1) is TX of peripheral p, slot 2(p-1)+1 is its RX.
  always_comb begin
    eligible = '0;
    for (int p = 1; p <= 31; p++) begin
      eligible[2*(p-1)]   = periph_tx_req[p] & periph_tx_en[p];
      eligible[2*(p-1)+1] = periph_rx_req[p] & periph_rx_en[p];
    end
  end

  // First eligible slot after rr_ptr, wrapping 61 -> 0; rr_ptr itself is checked last.
  always_comb begin
    win_found = 1'b0;
    win_slot  = '0;
    cand      = '0;
    for (int k = 1; k <= NSLOTS; k++) begin
      cand = {1'b0, rr_ptr} + 7'(k);
      if (cand >= 7'(NSLOTS)) begin
        cand = cand - 7'(NSLOTS);
      end
      if (!win_found && eligible[cand[5:0]]) begin
        win_found = 1'b1;
        win_slot  = cand[5:0];
      end
    end
  end

  always_comb begin
    served_tx = '0;
    served_rx = '0;
    for (int p = 1; p <= 31; p++) begin
      served_tx[p] = !grant_dir && (grant_periph == 5'(p));
      served_rx[p] =  grant_dir && (grant_periph == 5'(p));
    end
  end

  always_comb begin
    state_next        = state;
    rr_ptr_next       = rr_ptr;
    grant_valid_next  = grant_valid;
    grant_periph_next = grant_periph;
    grant_dir_next    = grant_dir;
    tx_clr_next       = '0;
    rx_clr_next       = '0;
`ifdef PERIPH_ARB_TIMEOUT_EN
    wd_cnt_next       = wd_cnt;
    xfer_timeout_next = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (win_found) begin
          state_next        = GRANT;
          grant_valid_next  = 1'b1;
          grant_periph_next = win_slot[5:1] + 5'd1;
          grant_dir_next    = win_slot[0];
        end
      end
      GRANT: begin
        // Grant is held until accepted, whatever the request lines do meanwhile.
        if (grant_ready) begin
          state_next       = BUSY;
          grant_valid_next = 1'b0;
          rr_ptr_next      = {grant_periph - 5'd1, grant_dir};
`ifdef PERIPH_ARB_TIMEOUT_EN
          wd_cnt_next      = '0;
`endif
        end
      end
      BUSY: begin
        if (xfer_done) begin
          state_next  = CLEAR;
          tx_clr_next = served_tx;
          rx_clr_next = served_rx;
        end
`ifdef PERIPH_ARB_TIMEOUT_EN
        else if (wd_expire) begin
          state_next        = CLEAR;
          tx_clr_next       = served_tx;
          rx_clr_next       = served_rx;
          xfer_timeout_next = 1'b1;
        end
        else begin
          wd_cnt_next = wd_cnt + 16'd1;
        end
`endif
      end
      CLEAR:   state_next = SETTLE;
      SETTLE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    arb_busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      rr_ptr        <= LAST_SLOT;
      grant_valid   <= 1'b0;
      grant_periph  <= '0;
      grant_dir     <= 1'b0;
      periph_tx_clr <= '0;
      periph_rx_clr <= '0;
      arb_busy      <= 1'b0;
`ifdef PERIPH_ARB_TIMEOUT_EN
      wd_cnt        <= '0;
      xfer_timeout  <= 1'b0;
`endif
    end else begin
      state         <= state_next;
      rr_ptr        <= rr_ptr_next;
      grant_valid   <= grant_valid_next;
      grant_periph  <= grant_periph_next;
      grant_dir     <= grant_dir_next;
      periph_tx_clr <= tx_clr_next;
      periph_rx_clr <= rx_clr_next;
      arb_busy      <= arb_busy_next;
`ifdef PERIPH_ARB_TIMEOUT_EN
      wd_cnt        <= wd_cnt_next;
      xfer_timeout  <= xfer_timeout_next;
`endif
    end
  end

  // Structural sanity: a single clear bit at a time, and only in CLEAR.
  assert property (@(posedge clk) disable iff (reset)
    $onehot0({periph_tx_clr, periph_rx_clr}));
  assert property (@(posedge clk) disable iff (reset)
    (|{periph_tx_clr, periph_rx_clr}) |-> (state == CLEAR));

endmodule

// File: tb/tb_periph_req_arbiter.sv
// Self-checking bench for periph_req_arbiter: directed test-plan steps plus randomized transfers
// against a slot-level round-robin model. Define PERIPH_ARB_TIMEOUT_EN to also cover the watchdog.
module tb_periph_req_arbiter;

  localparam int TB_TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:1] periph_tx_req, periph_rx_req, periph_tx_en, periph_rx_en;
  logic [31:1] periph_tx_clr, periph_rx_clr;
  logic        grant_valid;
  logic [4:0]  grant_periph;
  logic        grant_dir;
  logic        grant_ready;
  logic        xfer_done;
  logic        arb_busy;

  int assertCount = 0;
  int failCount   = 0;
  int lastServed  = 61;

  localparam logic [31:1] ALL_ONES = '1;

`ifdef PERIPH_ARB_TIMEOUT_EN
  logic xfer_timeout;

  periph_req_arbiter #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .periph_tx_req(periph_tx_req), .periph_rx_req(periph_rx_req),
    .periph_tx_en(periph_tx_en), .periph_rx_en(periph_rx_en),
    .periph_tx_clr(periph_tx_clr), .periph_rx_clr(periph_rx_clr),
    .grant_valid(grant_valid), .grant_periph(grant_periph), .grant_dir(grant_dir),
    .grant_ready(grant_ready), .xfer_done(xfer_done), .arb_busy(arb_busy),
    .xfer_timeout(xfer_timeout)
  );
`else
  periph_req_arbiter dut (
    .clk(clk), .reset(reset),
    .periph_tx_req(periph_tx_req), .periph_rx_req(periph_rx_req),
    .periph_tx_en(periph_tx_en), .periph_rx_en(periph_rx_en),
    .periph_tx_clr(periph_tx_clr), .periph_rx_clr(periph_rx_clr),
    .grant_valid(grant_valid), .grant_periph(grant_periph), .grant_dir(grant_dir),
    .grant_ready(grant_ready), .xfer_done(xfer_done), .arb_busy(arb_busy)
  );
`endif

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:1] bitFor(input int p);
    logic [31:1] v;
    v    = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  // Round-robin rule from the last served slot: scan last+1, last+2, ... modulo 62.
  function automatic int modelPick(input int last);
    for (int k = 1; k <= 62; k++) begin
      int s;
      int p;
      bit hit;
      s   = (last + k) % 62;
      p   = s / 2 + 1;
      hit = (s % 2 == 0) ? (periph_tx_req[p] && periph_tx_en[p])
                         : (periph_rx_req[p] && periph_rx_en[p]);
      if (hit) return s;
    end
    return -1;
  endfunction

  task automatic applyStimulus(input logic [31:1] txr, input logic [31:1] rxr,
                               input logic [31:1] txe, input logic [31:1] rxe);
    periph_tx_req = txr;
    periph_rx_req = rxr;
    periph_tx_en  = txe;
    periph_rx_en  = rxe;
  endtask

  task automatic checkClr(input string tag, input int slot);
    logic [31:1] expTx, expRx;
    expTx = '0;
    expRx = '0;
    if (slot >= 0) begin
      if (slot % 2 == 0) expTx[slot/2+1] = 1'b1;
      else               expRx[slot/2+1] = 1'b1;
    end
    checkOutput({tag, "_tx_clr"}, 32'(periph_tx_clr), 32'(expTx));
    checkOutput({tag, "_rx_clr"}, 32'(periph_rx_clr), 32'(expRx));
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkClr(tag, -1);
    checkOutput({tag, "_grant_valid"}, 32'(grant_valid), 0);
    checkOutput({tag, "_grant_periph"}, 32'(grant_periph), 0);
    checkOutput({tag, "_grant_dir"}, 32'(grant_dir), 0);
    checkOutput({tag, "_arb_busy"}, 32'(arb_busy), 0);
`ifdef PERIPH_ARB_TIMEOUT_EN
    checkOutput({tag, "_xfer_timeout"}, 32'(xfer_timeout), 0);
`endif
  endtask

  // One full transaction: wait for grant, optional ready stall, BUSY, CLEAR, SETTLE, IDLE.
  // Returns in the IDLE cycle (D+3) so the caller can change requests before the next pick.
  task automatic doTransfer(input string tag, input int wantSlot, input int readyDelay,
                            input int dropAt, input int doneDelay, input bit expectTimeout);
    int slot;
    int busyCycles;
    bit seen;
    slot = (wantSlot >= 0) ? wantSlot : modelPick(lastServed);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (grant_valid === 1'b1) seen = 1'b1;
      else tick();
    end
    checkOutput({tag, "_grant_valid"}, 32'(grant_valid), 1);
    if (!seen) return;
    checkOutput({tag, "_grant_periph"}, 32'(grant_periph), 32'(slot / 2 + 1));
    checkOutput({tag, "_grant_dir"}, 32'(grant_dir), 32'(slot % 2));
    checkOutput({tag, "_busy_in_grant"}, 32'(arb_busy), 1);
    for (int i = 0; i < readyDelay; i++) begin
      if (i == dropAt) begin
        if (slot % 2 == 0) periph_tx_req[slot/2+1] = 1'b0;
        else               periph_rx_req[slot/2+1] = 1'b0;
      end
      xfer_done = 1'b1;
      tick();
      checkOutput({tag, "_hold_valid"}, 32'(grant_valid), 1);
      checkOutput({tag, "_hold_periph"}, 32'(grant_periph), 32'(slot / 2 + 1));
      checkOutput({tag, "_hold_dir"}, 32'(grant_dir), 32'(slot % 2));
    end
    xfer_done   = 1'b0;
    grant_ready = 1'b1;
    tick();
    grant_ready = 1'b0;
    lastServed  = slot;
    checkOutput({tag, "_busy_valid_low"}, 32'(grant_valid), 0);
    checkOutput({tag, "_busy_flag"}, 32'(arb_busy), 1);
    busyCycles = expectTimeout ? TB_TIMEOUT : doneDelay + 1;
    for (int b = 1; b < busyCycles; b++) tick();
    checkClr({tag, "_busy"}, -1);
    checkOutput({tag, "_busy_end_valid"}, 32'(grant_valid), 0);
`ifdef PERIPH_ARB_TIMEOUT_EN
    checkOutput({tag, "_busy_no_timeout"}, 32'(xfer_timeout), 0);
`endif
    if (!expectTimeout) xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    checkClr({tag, "_clear"}, slot);
    checkOutput({tag, "_clear_busy"}, 32'(arb_busy), 1);
`ifdef PERIPH_ARB_TIMEOUT_EN
    checkOutput({tag, "_clear_timeout"}, 32'(xfer_timeout), 32'(expectTimeout));
`endif
    tick();
    checkClr({tag, "_settle"}, -1);
    checkOutput({tag, "_settle_valid"}, 32'(grant_valid), 0);
    checkOutput({tag, "_settle_busy"}, 32'(arb_busy), 1);
`ifdef PERIPH_ARB_TIMEOUT_EN
    checkOutput({tag, "_settle_timeout"}, 32'(xfer_timeout), 0);
`endif
    tick();
    checkOutput({tag, "_idle_busy"}, 32'(arb_busy), 0);
    checkOutput({tag, "_idle_valid"}, 32'(grant_valid), 0);
  endtask

  initial begin
    reset       = 1'b1;
    grant_ready = 1'b0;
    xfer_done   = 1'b0;
    applyStimulus('0, '0, '0, '0);
    tick();
    tick();
    checkIdleOutputs("reset");
    reset = 1'b0;
    tick();
    checkIdleOutputs("post_reset");

    $display("[TB] reset priority");
    applyStimulus(bitFor(1), bitFor(1), ALL_ONES, ALL_ONES);
    doTransfer("prio_tx", 0, 0, -1, 2, 1'b0);
    doTransfer("prio_rx", 1, 2, -1, 0, 1'b0);

    $display("[TB] round-robin fairness and wrap");
    applyStimulus(bitFor(3) | bitFor(31), bitFor(17), ALL_ONES, ALL_ONES);
    doTransfer("rr_3tx", 4, 0, -1, 0, 1'b0);
    doTransfer("rr_17rx", 33, 1, -1, 3, 1'b0);
    doTransfer("rr_31tx", 60, 0, -1, 1, 1'b0);
    doTransfer("rr_wrap_3tx", 4, 2, -1, 0, 1'b0);

    $display("[TB] enable mask");
    applyStimulus('0, bitFor(5), ALL_ONES, ALL_ONES & ~bitFor(5));
    xfer_done = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("mask_no_grant", 32'(grant_valid), 0);
      checkOutput("mask_not_busy", 32'(arb_busy), 0);
    end
    xfer_done       = 1'b0;
    periph_rx_en[5] = 1'b1;
    tick();
    checkOutput("mask_enable_grant", 32'(grant_valid), 1);
    doTransfer("mask", 9, 1, -1, 1, 1'b0);

    $display("[TB] handshake and turnaround timing");
    applyStimulus(bitFor(7) | bitFor(9), '0, ALL_ONES, ALL_ONES);
    doTransfer("hs", 12, 7, 3, 4, 1'b0);
    tick();
    checkOutput("hs_next_grant_d4", 32'(grant_valid), 1);
    checkOutput("hs_next_periph", 32'(grant_periph), 9);
    doTransfer("hs_next", 16, 0, -1, 0, 1'b0);

    $display("[TB] reset mid-transfer");
    applyStimulus(bitFor(1) | bitFor(26), bitFor(30), ALL_ONES, ALL_ONES);
    tick();
    checkOutput("mid_grant_valid", 32'(grant_valid), 1);
    checkOutput("mid_grant_periph", 32'(grant_periph), 26);
    grant_ready = 1'b1;
    tick();
    grant_ready = 1'b0;
    checkOutput("mid_in_busy", 32'(arb_busy), 1);
    tick();
    xfer_done = 1'b1;
    reset     = 1'b1;
    tick();
    xfer_done = 1'b0;
    checkIdleOutputs("mid_reset");
    reset      = 1'b0;
    lastServed = 61;
    tick();
    checkClr("mid_no_stale", -1);
    doTransfer("after_reset", 0, 0, -1, 0, 1'b0);

`ifdef PERIPH_ARB_TIMEOUT_EN
    $display("[TB] watchdog");
    applyStimulus(bitFor(4), '0, ALL_ONES, ALL_ONES);
    doTransfer("wd_expire", -1, 0, -1, 0, 1'b1);
    doTransfer("wd_done_wins", -1, 1, -1, TB_TIMEOUT - 1, 1'b0);
`endif

    $display("[TB] randomized transfers");
    for (int it = 0; it < 25; it++) begin
      applyStimulus(31'($urandom), 31'($urandom), 31'($urandom), 31'($urandom));
      if (modelPick(lastServed) < 0) begin
        periph_tx_req[1] = 1'b1;
        periph_tx_en[1]  = 1'b1;
      end
      doTransfer($sformatf("rand%0d", it), -1, int'($urandom_range(0, 3)), -1,
                 int'($urandom_range(0, 5)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
